// File: rtl/uart_txrx_core.sv
// uart_txrx_core
//   Independent UART transmitter and receiver sharing one clock.
//   Baud rate and parity are selected per frame and held for that whole frame.
//
// Parameters
//   CLK_FREQ      clock frequency in Hz; bit period DIV = CLK_FREQ / baud
//
// Ports
//   clock         system clock, all logic on the rising edge
//   reset         asynchronous, active-high reset
//   parity_type   00 none, 01 odd, 10 even, 11 none
//   baud_rate     00 2400, 01 4800, 10 9600, 11 19200
//   send          TX start request (level)
//   data_in       TX byte
//   data_tx       serial TX line, idle high
//   tx_active     high while a TX frame is in progress
//   tx_done       one-cycle pulse at the end of a TX frame
//   data_rx       serial RX line (asynchronous), idle high
//   data_out      last received byte
//   rx_active     high while an RX frame is in progress
//   rx_done       one-cycle pulse when a frame has been received
//   error_flag    bit0 parity error, bit1 start error, bit2 stop error
//   tx_state_dbg  current TX FSM state
//   rx_state_dbg  current RX FSM state
//
// Handshake: send is a level request. It is only looked at while the TX FSM
// is idle; on the edge that sees send=1 in idle, data_in, parity_type and
// baud_rate are captured and the start bit begins. send is ignored while a
// frame is active. If send is still high in the idle cycle that carries
// tx_done, the next frame starts on the following edge.
module uart_txrx_core #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic       send,
    input  logic [7:0] data_in,
    output logic       data_tx,
    output logic       tx_active,
    output logic       tx_done,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic [2:0] error_flag,
    output logic [2:0] tx_state_dbg,
    output logic [2:0] rx_state_dbg
);

    localparam int DIV_2400  = CLK_FREQ / 2400;
    localparam int DIV_4800  = CLK_FREQ / 4800;
    localparam int DIV_9600  = CLK_FREQ / 9600;
    localparam int DIV_19200 = CLK_FREQ / 19200;
    localparam int CNT_W     = $clog2(DIV_2400 + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic cnt_t div_sel(input logic [1:0] rate);
        case (rate)
            2'b00:   div_sel = cnt_t'(DIV_2400);
            2'b01:   div_sel = cnt_t'(DIV_4800);
            2'b10:   div_sel = cnt_t'(DIV_9600);
            default: div_sel = cnt_t'(DIV_19200);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t     tx_state, tx_state_n;
    cnt_t       tx_cnt, tx_cnt_n;
    cnt_t       tx_div, tx_div_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic [2:0] tx_idx, tx_idx_n;
    logic       tx_par_en, tx_par_en_n;
    logic       tx_par_bit, tx_par_bit_n;
    logic       tx_done_r, tx_done_n;
    logic       tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_div - cnt_t'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state   <= S_IDLE;
            tx_cnt     <= '0;
            tx_div     <= '0;
            tx_shift   <= 8'h00;
            tx_idx     <= 3'd0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_state   <= tx_state_n;
            tx_cnt     <= tx_cnt_n;
            tx_div     <= tx_div_n;
            tx_shift   <= tx_shift_n;
            tx_idx     <= tx_idx_n;
            tx_par_en  <= tx_par_en_n;
            tx_par_bit <= tx_par_bit_n;
            tx_done_r  <= tx_done_n;
        end
    end

    always_comb begin
        tx_state_n   = tx_state;
        tx_cnt_n     = tx_cnt;
        tx_div_n     = tx_div;
        tx_shift_n   = tx_shift;
        tx_idx_n     = tx_idx;
        tx_par_en_n  = tx_par_en;
        tx_par_bit_n = tx_par_bit;
        tx_done_n    = 1'b0;
        data_tx      = 1'b1;

        case (tx_state)
            S_START:  data_tx = 1'b0;
            S_DATA:   data_tx = tx_shift[0];
            S_PARITY: data_tx = tx_par_bit;
            default:  data_tx = 1'b1;
        endcase

        if (tx_state == S_IDLE) begin
            if (send) begin
                tx_state_n   = S_START;
                tx_cnt_n     = '0;
                tx_div_n     = div_sel(baud_rate);
                tx_shift_n   = data_in;
                tx_idx_n     = 3'd0;
                // Only 01 and 10 carry a parity bit.
                tx_par_en_n  = parity_type[0] ^ parity_type[1];
                tx_par_bit_n = (parity_type == 2'b01) ? ~(^data_in) : (^data_in);
            end
        end else if (tx_bit_end) begin
            tx_cnt_n = '0;
            case (tx_state)
                S_START: tx_state_n = S_DATA;
                S_DATA: begin
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_idx_n   = tx_idx + 3'd1;
                    if (tx_idx == 3'd7) begin
                        tx_state_n = tx_par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: tx_state_n = S_STOP;
                default: begin
                    tx_state_n = S_IDLE;
                    tx_done_n  = 1'b1;
                end
            endcase
        end else begin
            tx_cnt_n = tx_cnt + cnt_t'(1);
        end
    end

    assign tx_active    = (tx_state != S_IDLE);
    assign tx_done      = tx_done_r;
    assign tx_state_dbg = tx_state;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic       rx_meta, rx_sync, rx_prev;
    state_t     rx_state, rx_state_n;
    cnt_t       rx_cnt, rx_cnt_n;
    cnt_t       rx_div, rx_div_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic [2:0] rx_idx, rx_idx_n;
    logic       rx_par_en, rx_par_en_n;
    logic       rx_par_odd, rx_par_odd_n;
    logic       rx_par_bit, rx_par_bit_n;
    logic [7:0] data_out_r, data_out_n;
    logic [2:0] err_r, err_n;
    logic       rx_done_r, rx_done_n;
    logic       rx_bit_end, rx_half_end;

    assign rx_bit_end  = (rx_cnt == rx_div - cnt_t'(1));
    assign rx_half_end = (rx_cnt == (rx_div >> 1) - cnt_t'(1));

    // Synchronizer plus one extra flop for falling-edge detection; reset to
    // the idle (high) level so reset release never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= data_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_div     <= '0;
            rx_shift   <= 8'h00;
            rx_idx     <= 3'd0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
            data_out_r <= 8'h00;
            err_r      <= 3'b000;
            rx_done_r  <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_div     <= rx_div_n;
            rx_shift   <= rx_shift_n;
            rx_idx     <= rx_idx_n;
            rx_par_en  <= rx_par_en_n;
            rx_par_odd <= rx_par_odd_n;
            rx_par_bit <= rx_par_bit_n;
            data_out_r <= data_out_n;
            err_r      <= err_n;
            rx_done_r  <= rx_done_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt;
        rx_div_n     = rx_div;
        rx_shift_n   = rx_shift;
        rx_idx_n     = rx_idx;
        rx_par_en_n  = rx_par_en;
        rx_par_odd_n = rx_par_odd;
        rx_par_bit_n = rx_par_bit;
        data_out_n   = data_out_r;
        err_n        = err_r;
        rx_done_n    = 1'b0;

        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n   = S_START;
                    rx_cnt_n     = '0;
                    rx_div_n     = div_sel(baud_rate);
                    rx_par_en_n  = parity_type[0] ^ parity_type[1];
                    rx_par_odd_n = (parity_type == 2'b01);
                end
            end
            S_START: begin
                // Half a bit in: a high line means the falling edge was a glitch.
                if (rx_half_end) begin
                    rx_cnt_n = '0;
                    if (rx_sync) begin
                        rx_state_n = S_IDLE;
                        err_n      = 3'b010;
                        rx_done_n  = 1'b1;
                    end else begin
                        rx_state_n = S_DATA;
                        rx_idx_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + cnt_t'(1);
                end
            end
            default: begin
                if (rx_bit_end) begin
                    rx_cnt_n = '0;
                    case (rx_state)
                        S_DATA: begin
                            rx_shift_n = {rx_sync, rx_shift[7:1]};
                            rx_idx_n   = rx_idx + 3'd1;
                            if (rx_idx == 3'd7) begin
                                rx_state_n = rx_par_en ? S_PARITY : S_STOP;
                            end
                        end
                        S_PARITY: begin
                            rx_par_bit_n = rx_sync;
                            rx_state_n   = S_STOP;
                        end
                        default: begin
                            rx_state_n = S_IDLE;
                            data_out_n = rx_shift;
                            // XOR over data+parity is 1 for an odd count of ones.
                            err_n      = {~rx_sync, 1'b0,
                                          rx_par_en & ((^{rx_shift, rx_par_bit}) != rx_par_odd)};
                            rx_done_n  = 1'b1;
                        end
                    endcase
                end else begin
                    rx_cnt_n = rx_cnt + cnt_t'(1);
                end
            end
        endcase
    end

    assign rx_active    = (rx_state != S_IDLE);
    assign rx_done      = rx_done_r;
    assign data_out     = data_out_r;
    assign error_flag   = err_r;
    assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_txrx_core.sv
// Testbench for uart_txrx_core.
// The DUT runs with CLK_FREQ = 1 MHz so bit periods are 416/208/104/52 clocks
// (the 100 MHz periods divided by 100); frame lengths scale the same way.
module tb_uart_txrx_core;

  localparam int CLK_FREQ = 1_000_000;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       send;
  logic [7:0] data_in;
  logic       data_tx;
  logic       tx_active;
  logic       tx_done;
  logic       data_rx;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic [2:0] error_flag;
  logic [2:0] tx_state_dbg;
  logic [2:0] rx_state_dbg;

  logic loop_en;
  logic rx_drive;

  int total = 0;
  int bad = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;

  logic [7:0] exp_q[$];

  assign data_rx = loop_en ? data_tx : rx_drive;

  uart_txrx_core #(.CLK_FREQ(CLK_FREQ)) dut (
    .clock        (clock),
    .reset        (reset),
    .parity_type  (parity_type),
    .baud_rate    (baud_rate),
    .send         (send),
    .data_in      (data_in),
    .data_tx      (data_tx),
    .tx_active    (tx_active),
    .tx_done      (tx_done),
    .data_rx      (data_rx),
    .data_out     (data_out),
    .rx_active    (rx_active),
    .rx_done      (rx_done),
    .error_flag   (error_flag),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // Done pulses counted on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (tx_done) tx_done_cnt++;
    if (rx_done) rx_done_cnt++;
  end

  // ---------------- reference model helpers ----------------
  function automatic int bit_period(input logic [1:0] baud);
    int rate;
    rate = 2400 << baud;
    return CLK_FREQ / rate;
  endfunction

  function automatic logic parity_of(input logic [7:0] b, input logic [1:0] par);
    int ones;
    ones = $countones(b);
    if (par == 2'b01) return logic'(ones % 2 == 0);
    return logic'(ones % 2 == 1);
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge with TX idle; returns just after the
  // edge that starts the frame.
  task automatic start_tx(input logic [7:0] b, input logic [1:0] par,
                          input logic [1:0] baud, input bit keep_send);
    data_in = b;
    parity_type = par;
    baud_rate = baud;
    send = 1'b1;
    @(posedge clock); #1;
    if (!keep_send) send = 1'b0;
  endtask

  // Follows one TX frame from its first cycle (c=0) to the tx_done cycle.
  task automatic watch_tx(input logic [7:0] b, input logic [1:0] par,
                          input logic [1:0] baud, input string tag,
                          input bit scramble, input bit tail);
    logic exp_bits[$];
    int div;
    int nbits;
    div = bit_period(baud);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (par == 2'b01 || par == 2'b10) exp_bits.push_back(parity_of(b, par));
    exp_bits.push_back(1'b1);
    nbits = exp_bits.size();
    for (int c = 0; c <= nbits * div; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      if (scramble && c == 1) begin
        data_in = 8'($urandom);
        parity_type = 2'($urandom);
        baud_rate = 2'($urandom);
        send = 1'b1;
      end
      if (scramble && c == 2 * div) send = 1'b0;
      if (c == 0) begin
        total++;
        if (tx_done !== 1'b0) begin
          bad++;
          $display("FAIL %s tx_done_at_start got=%b exp=0", tag, tx_done);
        end
      end
      if (c < nbits * div && (c % div == 0 || c % div == div - 1)) begin
        total++;
        if (data_tx !== exp_bits[c / div] || tx_active !== 1'b1) begin
          bad++;
          $display("FAIL %s tx_bit%0d c=%0d got data_tx=%b active=%b exp data_tx=%b active=1",
                   tag, c / div, c, data_tx, tx_active, exp_bits[c / div]);
        end
      end
    end
    total++;
    if (tx_done !== 1'b1 || tx_active !== 1'b0 || data_tx !== 1'b1) begin
      bad++;
      $display("FAIL %s tx_end c=%0d got done=%b active=%b line=%b exp done=1 active=0 line=1",
               tag, nbits * div, tx_done, tx_active, data_tx);
    end
    if (tail) begin
      @(posedge clock); #1;
      total++;
      if (tx_done !== 1'b0 || tx_active !== 1'b0 || data_tx !== 1'b1) begin
        bad++;
        $display("FAIL %s tx_after_done got done=%b active=%b line=%b exp done=0 active=0 line=1",
                 tag, tx_done, tx_active, data_tx);
      end
    end
  endtask

  // Drives one RX frame from the bench, then one idle bit period.
  task automatic drive_rx_frame(input logic [7:0] b, input logic [1:0] par,
                                input bit bad_par, input logic stop_val,
                                input logic [1:0] baud);
    logic bits[$];
    int div;
    div = bit_period(baud);
    parity_type = par;
    baud_rate = baud;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par == 2'b01 || par == 2'b10) bits.push_back(parity_of(b, par) ^ bad_par);
    bits.push_back(stop_val);
    foreach (bits[i]) begin
      rx_drive = bits[i];
      repeat (div) @(posedge clock);
      #1;
    end
    rx_drive = 1'b1;
    repeat (div) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (data_tx !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_tx got line=%b active=%b done=%b exp 1/0/0", data_tx, tx_active, tx_done);
    end
    total++;
    if (rx_active !== 1'b0 || rx_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_rx got active=%b done=%b exp 0/0", rx_active, rx_done);
    end
    total++;
    if (data_out !== 8'h00 || error_flag !== 3'b000) begin
      bad++;
      $display("FAIL reset_rx_regs got data_out=%h err=%b exp 00/000", data_out, error_flag);
    end
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_tx_odd_parity();
    start_tx(8'h53, 2'b01, 2'b10, 1'b0);
    watch_tx(8'h53, 2'b01, 2'b10, "tx_53_odd", 1'b1, 1'b1);
  endtask

  task automatic test_tx_no_parity();
    start_tx(8'hFF, 2'b00, 2'b00, 1'b0);
    watch_tx(8'hFF, 2'b00, 2'b00, "tx_ff_none", 1'b1, 1'b1);
    start_tx(8'h3C, 2'b11, 2'b11, 1'b0);
    watch_tx(8'h3C, 2'b11, 2'b11, "tx_3c_par11", 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1;
    logic [7:0] b2;
    logic [1:0] par;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    par = 2'($urandom_range(0, 3));
    start_tx(b1, par, 2'b11, 1'b1);
    watch_tx(b1, par, 2'b11, "b2b_first", 1'b0, 1'b0);
    data_in = b2;
    @(posedge clock); #1;
    send = 1'b0;
    watch_tx(b2, par, 2'b11, "b2b_second", 1'b0, 1'b1);
  endtask

  task automatic test_loopback();
    int snap;
    logic [7:0] b;
    logic [7:0] exp_b;
    logic [1:0] par;
    logic [1:0] baud;
    loop_en = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    for (int n = 0; n < 7; n++) begin
      if (n == 0) begin
        b = 8'hA5; par = 2'b10; baud = 2'b11;
      end else begin
        b = 8'($urandom);
        par = 2'($urandom_range(0, 3));
        baud = 2'($urandom_range(2, 3));
      end
      exp_q.push_back(b);
      snap = rx_done_cnt;
      start_tx(b, par, baud, 1'b0);
      watch_tx(b, par, baud, "loop_tx", 1'b0, 1'b1);
      exp_b = exp_q.pop_front();
      total++;
      if (rx_done_cnt - snap !== 1 || data_out !== exp_b || error_flag !== 3'b000) begin
        bad++;
        $display("FAIL loop_rx n=%0d got done_pulses=%0d data_out=%h err=%b exp 1/%h/000",
                 n, rx_done_cnt - snap, data_out, error_flag, exp_b);
      end
      total++;
      if (rx_active !== 1'b0) begin
        bad++;
        $display("FAIL loop_rx_idle n=%0d got rx_active=%b exp 0", n, rx_active);
      end
    end
    loop_en = 1'b0;
    rx_drive = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_rx_parity_err();
    int snap;
    snap = rx_done_cnt;
    drive_rx_frame(8'h30, 2'b01, 1'b1, 1'b1, 2'b10);
    total++;
    if (rx_done_cnt - snap !== 1 || data_out !== 8'h30 || error_flag !== 3'b001) begin
      bad++;
      $display("FAIL rx_parity_err got pulses=%0d data_out=%h err=%b exp 1/30/001",
               rx_done_cnt - snap, data_out, error_flag);
    end
  endtask

  task automatic test_rx_stop_and_glitch();
    int snap;
    logic [7:0] b;
    b = 8'($urandom);
    snap = rx_done_cnt;
    drive_rx_frame(b, 2'b10, 1'b0, 1'b0, 2'b10);
    total++;
    if (rx_done_cnt - snap !== 1 || data_out !== b || error_flag !== 3'b100) begin
      bad++;
      $display("FAIL rx_stop_err got pulses=%0d data_out=%h err=%b exp 1/%h/100",
               rx_done_cnt - snap, data_out, error_flag, b);
    end
    // Low glitch well under half a bit at 9600.
    snap = rx_done_cnt;
    baud_rate = 2'b10;
    parity_type = 2'b00;
    rx_drive = 1'b0;
    repeat (bit_period(2'b10) / 5) @(posedge clock);
    #1;
    rx_drive = 1'b1;
    repeat (2 * bit_period(2'b10)) @(posedge clock);
    #1;
    total++;
    if (rx_done_cnt - snap !== 1 || data_out !== b || error_flag !== 3'b010) begin
      bad++;
      $display("FAIL rx_glitch got pulses=%0d data_out=%h err=%b exp 1/%h/010",
               rx_done_cnt - snap, data_out, error_flag, b);
    end
    total++;
    if (rx_active !== 1'b0) begin
      bad++;
      $display("FAIL rx_glitch_idle got rx_active=%b exp 0", rx_active);
    end
  endtask

  task automatic test_reset_mid_tx();
    int snap;
    int div;
    logic [7:0] b;
    b = 8'($urandom);
    div = bit_period(2'b11);
    start_tx(b, 2'b01, 2'b11, 1'b0);
    repeat (4 * div + div / 2) @(posedge clock);
    #1;
    total++;
    if (tx_active !== 1'b1 || data_tx !== b[3]) begin
      bad++;
      $display("FAIL rst_mid_bit3 got active=%b line=%b exp 1/%b", tx_active, data_tx, b[3]);
    end
    snap = tx_done_cnt;
    reset = 1'b1;
    #1;
    total++;
    if (data_tx !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_immediate got line=%b active=%b done=%b exp 1/0/0",
               data_tx, tx_active, tx_done);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2 * div) @(posedge clock);
    #1;
    total++;
    if (tx_done_cnt !== snap || data_tx !== 1'b1 || data_out !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_no_done got pulses=%0d line=%b data_out=%h exp 0/1/00",
               tx_done_cnt - snap, data_tx, data_out);
    end
    b = 8'($urandom);
    start_tx(b, 2'b01, 2'b11, 1'b0);
    watch_tx(b, 2'b01, 2'b11, "after_reset", 1'b0, 1'b1);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    reset = 1'b1;
    parity_type = 2'b00;
    baud_rate = 2'b00;
    send = 1'b0;
    data_in = 8'h00;
    loop_en = 1'b0;
    rx_drive = 1'b1;
    @(negedge clock);
    test_reset();
    test_tx_odd_parity();
    test_tx_no_parity();
    test_back_to_back();
    test_loopback();
    test_rx_parity_err();
    test_rx_stop_and_glitch();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_txrx_core.md
UART_TXRX_CORE -- requirements
Module: uart_txrx_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, clock frequency in Hz used for baud divisors.
REQ-002 SHALL have port clock  input  1  single system clock, all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-005 SHALL have port baud_rate  input  2  00 2400, 01 4800, 10 9600, 11 19200 baud.
REQ-006 SHALL have port send  input  1  TX start request, level-sensitive.
REQ-007 SHALL have port data_in  input  8  TX byte.
REQ-008 SHALL have port data_tx  output  1  serial TX line, idle high.
REQ-009 SHALL have port tx_active  output  1  high while a TX frame is in progress.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at TX frame end.
REQ-011 SHALL have port data_rx  input  1  serial RX line, asynchronous, idle high.
REQ-012 SHALL have port data_out  output  8  last received byte.
REQ-013 SHALL have port rx_active  output  1  high while an RX frame is in progress.
REQ-014 SHALL have port rx_done  output  1  one-cycle pulse when a received byte is valid.
REQ-015 SHALL have port error_flag  output  3  bit0 parity error, bit1 start error, bit2 stop error.

Function
REQ-016 SHALL use bit period DIV = floor(CLK_FREQ/baud); at 100 MHz: 41666, 20833, 10416, 5208 clocks.
REQ-017 SHALL sample parity_type and baud_rate at frame start; changes mid-frame have no effect until the next frame.
REQ-018 Frame SHALL be: start 0, 8 data bits LSB first, parity bit only for 01/10, stop 1; 11 bits with parity, 10 without.
REQ-019 Odd parity SHALL make the total count of ones in data plus parity odd; even parity SHALL make it even.
REQ-020 TX states SHALL be IDLE, START, DATA, PARITY (skipped when no parity), STOP.
REQ-021 In IDLE with send=1, TX SHALL latch data_in and enter START on the next edge, with tx_active=1 and data_tx=0 from that edge.
REQ-022 Each TX bit SHALL be driven for exactly DIV clocks.
REQ-023 At the end of STOP, TX SHALL pulse tx_done for one cycle, drop tx_active in the same cycle, and return to IDLE.
REQ-024 TX SHALL ignore send while active.
REQ-025 If send is still high in IDLE, TX SHALL start a new frame on the cycle after tx_done.
REQ-026 RX SHALL pass data_rx through a 2-flop synchronizer before any logic.
REQ-027 RX states SHALL be IDLE, START, DATA, PARITY (skipped when no parity), STOP.
REQ-028 On a synchronized falling edge in IDLE, RX SHALL enter START, set rx_active=1 and wait DIV/2 clocks.
REQ-029 If the line is high at the START mid-sample, RX SHALL set error_flag bit1, pulse rx_done and return to IDLE without updating data_out.
REQ-030 After a valid start, RX SHALL sample each further bit every DIV clocks at mid-bit, shifting data LSB first.
REQ-031 At the STOP mid-sample, RX SHALL update data_out, set error_flag bit0 on parity mismatch and bit2 if stop=0, pulse rx_done for one cycle, drop rx_active and return to IDLE.
REQ-032 error_flag SHALL be updated only when rx_done pulses and hold its value until the next rx_done.
REQ-033 TX and RX SHALL operate fully independently and simultaneously.

Reset
REQ-034 While reset=1: data_tx=1, tx_active=0, tx_done=0, rx_active=0, rx_done=0, data_out=8'h00, error_flag=3'b000, all counters cleared, both FSMs in IDLE.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse, and leave outputs at reset values.

Verification
REQ-036 Bench SHALL cover: baud 10, parity 01, send byte 0x53 -> data_tx bits 0,1,1,0,0,1,0,1,0,1(parity),1, each 10416 clocks; tx_done after 114576 clocks.
REQ-037 Bench SHALL cover: data_tx looped to data_rx, baud 11, parity 10, byte 0xA5 -> rx_done once, data_out=0xA5, error_flag=000.
REQ-038 Bench SHALL cover: RX frame 0x30 with odd parity and parity bit forced wrong -> data_out=0x30, error_flag=001.
REQ-039 Bench SHALL cover: RX frame with stop bit driven 0 -> error_flag=100; a 2000-clock low glitch at 9600 -> error_flag=010 and data_out unchanged.
REQ-040 Bench SHALL cover: parity 00, baud 00, byte 0xFF -> 10-bit frame of 41666-clock bits, tx_done after 416660 clocks.
REQ-041 Bench SHALL cover: reset pulsed during TX DATA bit 3 -> data_tx=1 and tx_active=0 immediately, no tx_done; the next send transmits a complete frame.
